// File: rtl/cpu_run_checker_if.sv
// Bus between the monitored cpu core (plus test harness) and the run checker.
// The master side drives strobes, start and the check table; the checker reports status.
interface cpu_run_checker_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int NUM_CHK = 4,
  parameter int CNT_W   = 16
);
  logic                       start;
  logic                       pc_write;
  logic [ADDR_W-1:0]          pc_val;
  logic                       ir_write;
  logic                       reg_write;
  logic                       mem_write;
  logic [ADDR_W-1:0]          mem_addr;
  logic [DATA_W-1:0]          mem_wdata;
  logic [NUM_CHK*ADDR_W-1:0]  chk_addr;
  logic [NUM_CHK*DATA_W-1:0]  chk_exp;
  logic                       busy;
  logic                       done;
  logic                       pass;
  logic                       timeout;
  logic [NUM_CHK-1:0]         fail_mask;
  logic [CNT_W-1:0]           cycle_cnt;
  logic [CNT_W-1:0]           inst_cnt;
  logic [CNT_W-1:0]           regw_cnt;
  logic [CNT_W-1:0]           memw_cnt;

  modport master (
    output start, pc_write, pc_val, ir_write, reg_write, mem_write, mem_addr, mem_wdata,
           chk_addr, chk_exp,
    input  busy, done, pass, timeout, fail_mask, cycle_cnt, inst_cnt, regw_cnt, memw_cnt
  );

  modport slave (
    input  start, pc_write, pc_val, ir_write, reg_write, mem_write, mem_addr, mem_wdata,
           chk_addr, chk_exp,
    output busy, done, pass, timeout, fail_mask, cycle_cnt, inst_cnt, regw_cnt, memw_cnt
  );
endinterface

// File: rtl/cpu_run_checker.sv
// Run monitor for the multi-cycle cpu core: counts events, detects the jump-to-self halt,
// compares captured stores against an expected table and reports pass/fail/timeout.

// One check channel: latched address/expected value, last captured store, seen flag.
module cpu_run_chk_lane #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              cap_en,
  input  logic              eval,
  input  logic [ADDR_W-1:0] chk_addr,
  input  logic [DATA_W-1:0] chk_exp,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              fail
);
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] exp_q, exp_d, cap_q, cap_d;
  logic              seen_q, seen_d, fail_q, fail_d;

  always_comb begin
    addr_d = addr_q;
    exp_d  = exp_q;
    cap_d  = cap_q;
    seen_d = seen_q;
    fail_d = fail_q;
    if (load) begin
      addr_d = chk_addr;
      exp_d  = chk_exp;
      cap_d  = '0;
      seen_d = 1'b0;
      fail_d = 1'b0;
    end else begin
      // last write wins
      if (cap_en && (mem_addr == addr_q)) begin
        cap_d  = mem_wdata;
        seen_d = 1'b1;
      end
      if (eval) fail_d = !seen_q || (cap_q != exp_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      exp_q  <= '0;
      cap_q  <= '0;
      seen_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      exp_q  <= exp_d;
      cap_q  <= cap_d;
      seen_q <= seen_d;
      fail_q <= fail_d;
    end
  end

  assign fail = fail_q;
endmodule

module cpu_run_checker #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int NUM_CHK     = 4,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 2500
) (
  input  logic                clk,
  input  logic                rst_n,
  cpu_run_checker_if.slave    bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d, inst_q, inst_d, regw_q, regw_d, memw_q, memw_d;
  logic [ADDR_W-1:0]  last_pc_q, last_pc_d;
  logic               timeout_q, timeout_d, done_q, done_d, pass_q, pass_d;
  logic               load, cap_en, eval, halt;
  logic [NUM_CHK-1:0] lane_fail;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + 1'b1 : v;
  endfunction

  assign halt = bus.pc_write && (bus.pc_val == last_pc_q);

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    inst_d    = inst_q;
    regw_d    = regw_q;
    memw_d    = memw_q;
    last_pc_d = last_pc_q;
    timeout_d = timeout_q;
    done_d    = done_q;
    pass_d    = pass_q;
    load      = 1'b0;
    cap_en    = 1'b0;
    eval      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d   = S_RUN;
          load      = 1'b1;
          cyc_d     = '0;
          inst_d    = '0;
          regw_d    = '0;
          memw_d    = '0;
          last_pc_d = '0;
          timeout_d = 1'b0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
        end else if (state_q == S_DONE) begin
          done_d = 1'b1;
          pass_d = !timeout_q && !(|lane_fail);
        end
      end
      S_RUN: begin
        cyc_d  = sat_inc(cyc_q, 1'b1);
        inst_d = sat_inc(inst_q, bus.ir_write);
        regw_d = sat_inc(regw_q, bus.reg_write);
        memw_d = sat_inc(memw_q, bus.mem_write);
        cap_en = bus.mem_write;
        if (bus.pc_write) last_pc_d = bus.pc_val;
        // a halt on the final allowed cycle takes priority over the timeout
        if (halt) begin
          state_d = S_CHECK;
        end else if (cyc_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        eval    = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      inst_q    <= '0;
      regw_q    <= '0;
      memw_q    <= '0;
      last_pc_q <= '0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      inst_q    <= inst_d;
      regw_q    <= regw_d;
      memw_q    <= memw_d;
      last_pc_q <= last_pc_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  for (genvar i = 0; i < NUM_CHK; i++) begin : g_lane
    cpu_run_chk_lane #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .cap_en    (cap_en),
      .eval      (eval),
      .chk_addr  (bus.chk_addr[i*ADDR_W +: ADDR_W]),
      .chk_exp   (bus.chk_exp[i*DATA_W +: DATA_W]),
      .mem_addr  (bus.mem_addr),
      .mem_wdata (bus.mem_wdata),
      .fail      (lane_fail[i])
    );
  end

  assign bus.busy      = (state_q == S_RUN) || (state_q == S_CHECK);
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.timeout   = timeout_q;
  assign bus.fail_mask = lane_fail;
  assign bus.cycle_cnt = cyc_q;
  assign bus.inst_cnt  = inst_q;
  assign bus.regw_cnt  = regw_q;
  assign bus.memw_cnt  = memw_q;
endmodule
